md_unit: RTL and testbench

- Multiply/divide unit in the EX stage of the five-stage MIPS pipeline.
- Consumes mult/multu/div/divu/mthi/mtlo operations issued from the ID/EX pipeline register and owns the architectural HI/LO registers.
- Models the fixed multi-cycle latency of multiply and divide with a busy counter.
- Produces the stall request the hazard logic uses to freeze the PC and IF/ID and to bubble ID/EX while an HI/LO-touching instruction is in ID.

---
 rtl/md_unit_if.sv | 31 +++
 rtl/md_unit.sv | 160 ++++++++++++++++
 tb/tb_md_unit.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// ============================================================================
// Module      : md_unit_if
// Description : EX-stage multiply/divide issue bus and HI/LO result signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        id_is_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;

  // master: the EX/hazard side issuing ops; slave: the md_unit itself
  modport master (
    output start, md_op, rs_val, rt_val, id_is_md,
    input  busy, hi, lo, md_stall
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, id_is_md,
    output busy, hi, lo, md_stall
  );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle MIPS multiply/divide unit owning HI/LO and
//               raising the pipeline stall request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   bus
);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  localparam logic [3:0] c_mult_cyc = 4'(MULT_CYC);
  localparam logic [3:0] c_div_cyc  = 4'(DIV_CYC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic [31:0] r_res_hi, w_res_hi_nxt;
  logic [31:0] r_res_lo, w_res_lo_nxt;
  logic        r_res_wr, w_res_wr_nxt;

  // ---------------------------------------------------------------- datapath
  logic [63:0] w_rs_sx, w_rt_sx, w_prod_s, w_prod_u;
  logic [31:0] w_rs_mag, w_rt_mag, w_sden, w_sq_mag, w_sr_mag, w_sq, w_sr;
  logic [31:0] w_uden, w_uq, w_ur;
  logic        w_rt_zero;

  assign w_rs_sx  = {{32{bus.rs_val[31]}}, bus.rs_val};
  assign w_rt_sx  = {{32{bus.rt_val[31]}}, bus.rt_val};
  assign w_prod_s = w_rs_sx * w_rt_sx;
  assign w_prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

  // Signed divide on magnitudes avoids the INT_MIN / -1 overflow corner.
  assign w_rt_zero = (bus.rt_val == 32'd0);
  assign w_rs_mag  = bus.rs_val[31] ? (~bus.rs_val + 32'd1) : bus.rs_val;
  assign w_rt_mag  = bus.rt_val[31] ? (~bus.rt_val + 32'd1) : bus.rt_val;
  assign w_sden    = w_rt_zero ? 32'd1 : w_rt_mag;
  assign w_sq_mag  = w_rs_mag / w_sden;
  assign w_sr_mag  = w_rs_mag % w_sden;
  assign w_sq      = (bus.rs_val[31] ^ bus.rt_val[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sr      = bus.rs_val[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;

  assign w_uden = w_rt_zero ? 32'd1 : bus.rt_val;
  assign w_uq   = bus.rs_val / w_uden;
  assign w_ur   = bus.rs_val % w_uden;

  // ------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_res_hi_nxt = r_res_hi;
    w_res_lo_nxt = r_res_lo;
    w_res_wr_nxt = r_res_wr;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.md_op)
            c_op_mult: begin
              {w_res_hi_nxt, w_res_lo_nxt} = w_prod_s;
              w_res_wr_nxt = 1'b1;
              w_cnt_nxt    = c_mult_cyc;
              w_state_nxt  = ST_RUN;
            end
            c_op_multu: begin
              {w_res_hi_nxt, w_res_lo_nxt} = w_prod_u;
              w_res_wr_nxt = 1'b1;
              w_cnt_nxt    = c_mult_cyc;
              w_state_nxt  = ST_RUN;
            end
            c_op_div: begin
              w_res_hi_nxt = w_sr;
              w_res_lo_nxt = w_sq;
              w_res_wr_nxt = !w_rt_zero;
              w_cnt_nxt    = c_div_cyc;
              w_state_nxt  = ST_RUN;
            end
            c_op_divu: begin
              w_res_hi_nxt = w_ur;
              w_res_lo_nxt = w_uq;
              w_res_wr_nxt = !w_rt_zero;
              w_cnt_nxt    = c_div_cyc;
              w_state_nxt  = ST_RUN;
            end
            c_op_mthi: w_hi_nxt = bus.rs_val;
            c_op_mtlo: w_lo_nxt = bus.rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // start is ignored here; the hazard unit should never issue now
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_IDLE;
          if (r_res_wr) begin
            w_hi_nxt = r_res_hi;
            w_lo_nxt = r_res_lo;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_res_wr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_res_hi <= w_res_hi_nxt;
      r_res_lo <= w_res_lo_nxt;
      r_res_wr <= w_res_wr_nxt;
    end
  end

  // --------------------------------------------------------------- outputs
  logic w_issue_md;
  assign w_issue_md = bus.start && ((bus.md_op == c_op_mult) || (bus.md_op == c_op_multu) ||
                                    (bus.md_op == c_op_div)  || (bus.md_op == c_op_divu));

  assign bus.busy     = (r_state == ST_RUN);
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.md_stall = bus.id_is_md && (bus.busy || w_issue_md);

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module      : tb_md_unit
// Description : Scoreboard bench for md_unit: results and busy length are
//               queued at issue and compared when busy falls.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_md_unit;

  localparam int c_mult_cyc = 5;
  localparam int c_div_cyc  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  md_unit_if bus();

  md_unit #(.MULT_CYC(c_mult_cyc), .DIV_CYC(c_div_cyc)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built on 64-bit integer arithmetic
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t    e;
    longint  sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.cyc = (op == OP_MULT || op == OP_MULTU) ? c_mult_cyc : c_div_cyc;
    case (op)
      OP_MULT: begin
        q = sa * sb;
        e.hi = q[63:32];
        e.lo = q[31:0];
      end
      OP_MULTU: begin
        p = ua * ub;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      OP_DIV: if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        e.lo = q[31:0];
        e.hi = r[31:0];
      end
      OP_DIVU: if (b != 32'd0) begin
        p = ua / ub;
        e.lo = p[31:0];
        p = ua % ub;
        e.hi = p[31:0];
      end
      default: ;
    endcase
    return e;
  endfunction

  // Completion monitor: pops the scoreboard on every busy falling edge
  int   busy_len  = 0;
  logic prev_busy = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      busy_len  = 0;
      prev_busy = 1'b0;
    end else begin
      if (bus.busy) busy_len++;
      else if (prev_busy) begin
        if (sb_q.size() == 0) check("spurious_done", 64'(sb_q.size()), 64'd1);
        else begin
          mon_e = sb_q.pop_front();
          check("done_hi",  64'(bus.hi),  64'(mon_e.hi));
          check("done_lo",  64'(bus.lo),  64'(mon_e.lo));
          check("busy_len", 64'(busy_len), 64'(mon_e.cyc));
        end
        busy_len = 0;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    sb_q.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    tick();
    bus.start = 1'b0;
    bus.md_op = OP_NONE;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = v;
    tick();
    bus.start = 1'b0;
    bus.md_op = OP_NONE;
    if (op == OP_MTHI) m_hi = v; else m_lo = v;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    check("timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] h, input logic [31:0] l);
    check({tag, "_hi"}, 64'(bus.hi), 64'(h));
    check({tag, "_lo"}, 64'(bus.lo), 64'(l));
  endtask

  initial begin
    int stall_cnt;
    bus.start    = 1'b0;
    bus.md_op    = OP_NONE;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    bus.id_is_md = 1'b0;

    repeat (2) tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check_hilo("rst", 32'd0, 32'd0);
    reset = 1'b0;
    tick();

    issue(OP_MULT, 32'hFFFFFFFF, 32'h2);
    check("mult_busy1", 64'(bus.busy), 64'd1);
    wait_done();
    check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'h2);
    wait_done();
    check_hilo("multu", 32'h00000001, 32'hFFFFFFFE);

    issue(OP_DIV, 32'hFFFFFFF9, 32'h2);
    wait_done();
    check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    issue(OP_DIVU, 32'hFFFFFFF9, 32'h2);
    wait_done();
    check_hilo("divu", 32'h00000001, 32'h7FFFFFFC);

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done();
    check_hilo("div_ovf", 32'h00000000, 32'h80000000);

    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done();
    check_hilo("divu_by0", 32'h11, 32'h22);

    // Back-to-back MTHI / MTLO
    mt(OP_MTHI, 32'hDEADBEEF);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    check_hilo("mthi", 32'hDEADBEEF, 32'h22);
    mt(OP_MTLO, 32'h12345678);
    check("mtlo_busy", 64'(bus.busy), 64'd0);
    check_hilo("mtlo", 32'hDEADBEEF, 32'h12345678);

    // NONE / reserved opcodes do nothing and do not stall
    bus.id_is_md = 1'b1;
    bus.start    = 1'b1;
    bus.md_op    = OP_NONE;
    bus.rs_val   = 32'hA5A5A5A5;
    @(negedge clk);
    check("none_stall", 64'(bus.md_stall), 64'd0);
    tick();
    bus.md_op = OP_RSVD;
    @(negedge clk);
    check("rsvd_stall", 64'(bus.md_stall), 64'd0);
    tick();
    bus.md_op = OP_MTHI;
    @(negedge clk);
    check("mthi_stall", 64'(bus.md_stall), 64'd0);
    bus.start = 1'b0;
    bus.md_op = OP_NONE;
    tick();
    check("none_busy", 64'(bus.busy), 64'd0);
    check_hilo("none", 32'hDEADBEEF, 32'h12345678);

    // Stall covers issue cycle plus every busy cycle
    stall_cnt = 0;
    begin
      exp_t e;
      e = model(OP_MULT, 32'd6, 32'd7);
      sb_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end
    bus.start  = 1'b1;
    bus.md_op  = OP_MULT;
    bus.rs_val = 32'd6;
    bus.rt_val = 32'd7;
    @(negedge clk);
    stall_cnt += int'(bus.md_stall);
    tick();
    bus.start = 1'b0;
    bus.md_op = OP_NONE;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      stall_cnt += int'(bus.md_stall);
    end
    check("stall_cycles", 64'(stall_cnt), 64'd6);
    check("stall_after", 64'(bus.md_stall), 64'd0);
    tick();
    wait_done();
    check_hilo("stall_mult", 32'd0, 32'd42);

    // No stall at all when ID holds no MD instruction
    bus.id_is_md = 1'b0;
    stall_cnt = 0;
    issue(OP_DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      stall_cnt += int'(bus.md_stall);
      tick();
    end
    check("no_id_stall", 64'(stall_cnt), 64'd0);
    wait_done();
    check_hilo("divu_100_7", 32'd2, 32'd14);

    // A start while busy must be harmless
    issue(OP_MULT, 32'd3, 32'hFFFFFFFB);
    tick();
    bus.start  = 1'b1;
    bus.md_op  = OP_DIV;
    bus.rs_val = 32'd50;
    bus.rt_val = 32'd3;
    tick();
    bus.start = 1'b0;
    bus.md_op = OP_NONE;
    wait_done();
    check_hilo("ignored_start", 32'hFFFFFFFF, 32'hFFFFFFF1);
    repeat (12) tick();
    check("ignored_busy", 64'(bus.busy), 64'd0);
    check_hilo("ignored_late", 32'hFFFFFFFF, 32'hFFFFFFF1);

    // Reset on the third busy cycle of a divide
    issue(OP_DIV, 32'd1000, 32'd3);
    tick();
    tick();
    reset = 1'b1;
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check_hilo("midrst", 32'd0, 32'd0);
    reset = 1'b0;
    repeat (15) tick();
    check("midrst_busy_late", 64'(bus.busy), 64'd0);
    check_hilo("midrst_late", 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
